// File: rtl/pd_regs_pkg.sv
// Shared definitions for the PD controller register path: FSM encodings,
// default bus widths and well-known register addresses.
package pd_regs_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DONE  = 4'b1000
    } arb_state_t;

    localparam logic [7:0] ADDR_DEVID  = 8'h14;
    localparam logic [7:0] ADDR_CTRL   = 8'h20;
    localparam logic [7:0] ADDR_STATUS = 8'h21;

    // Data returned to a requester whose bank access timed out.
    localparam logic [15:0] ERR_RDATA = 16'hFFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester picker: round-robin by default, or port 0 always wins ties
// when FIXED_PRIO is non-zero. Holds the last-served port.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic served,
    output logic gnt_valid,
    output logic gnt_idx
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_idx = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            gnt_idx = req1 & ~req0;
        end
        last_grant_d = upd ? served : last_grant_q;
    end

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Serialises register-bank accesses from the I2C slave (port 0) and the PD
// engine (port 1); one bank transaction at a time, bounded by a timeout.
module reg_access_arbiter
    import pd_regs_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              rnw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              done0,
    output logic              err0,
    input  logic              req1,
    input  logic              rnw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              done1,
    output logic              err1,
    output logic              bank_req,
    output logic              bank_rnw,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata,
    input  logic              bank_ack,
    output logic              busy
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              sel_q, sel_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              bank_req_q, bank_req_d;
    logic              bank_rnw_q, bank_rnw_d;
    logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
    logic [DATA_W-1:0] bank_wdata_q, bank_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              gnt_valid, gnt_idx;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .upd      (state_q == ST_DONE),
        .served   (sel_q),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        bank_req_d   = 1'b0;
        bank_rnw_d   = bank_rnw_q;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    sel_d        = gnt_idx;
                    bank_rnw_d   = gnt_idx ? rnw1 : rnw0;
                    bank_addr_d  = gnt_idx ? addr1 : addr0;
                    bank_wdata_d = gnt_idx ? wdata1 : wdata0;
                    cnt_d        = 8'd0;
                    bank_req_d   = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Ack is checked before the timeout so a coincident ack wins.
                if (bank_ack) begin
                    if (bank_rnw_q) begin
                        if (sel_q) rdata1_d = bank_rdata;
                        else       rdata0_d = bank_rdata;
                    end
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (sel_q) rdata1_d = DATA_W'(ERR_RDATA);
                    else       rdata0_d = DATA_W'(ERR_RDATA);
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    err0_d  = ~sel_q;
                    err1_d  = sel_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            cnt_q        <= 8'd0;
            bank_req_q   <= 1'b0;
            bank_rnw_q   <= 1'b0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            bank_req_q   <= bank_req_d;
            bank_rnw_q   <= bank_rnw_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign bank_req   = bank_req_q;
    assign bank_rnw   = bank_rnw_q;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: round-robin instance plus a
// fixed-priority instance, one line printed per transaction.
module tb_reg_access_arbiter;
    import pd_regs_pkg::*;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, rnw0, req1, rnw1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1, rdata0, rdata1;
    logic        done0, err0, done1, err1;
    logic        bank_req, bank_rnw, bank_ack, busy;
    logic [7:0]  bank_addr;
    logic [15:0] bank_wdata, bank_rdata;

    logic        f_req0, f_req1, f_done0, f_err0, f_done1, f_err1;
    logic        f_bank_req, f_bank_rnw, f_bank_ack, f_busy;
    logic [7:0]  f_bank_addr;
    logic [15:0] f_rdata0, f_rdata1, f_bank_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_rd0 = 16'h0;
    logic [15:0] exp_rd1 = 16'h0;

    always #5 clk = ~clk;

    reg_access_arbiter #(.TIMEOUT(TIMEOUT), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .done0(done0), .err0(err0),
        .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .done1(done1), .err1(err1),
        .bank_req(bank_req), .bank_rnw(bank_rnw), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .bank_ack(bank_ack),
        .busy(busy)
    );

    reg_access_arbiter #(.TIMEOUT(TIMEOUT), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(f_req0), .rnw0(1'b1), .addr0(8'h40), .wdata0(16'h0000),
        .rdata0(f_rdata0), .done0(f_done0), .err0(f_err0),
        .req1(f_req1), .rnw1(1'b1), .addr1(8'h41), .wdata1(16'h0000),
        .rdata1(f_rdata1), .done1(f_done1), .err1(f_err1),
        .bank_req(f_bank_req), .bank_rnw(f_bank_rnw), .bank_addr(f_bank_addr),
        .bank_wdata(f_bank_wdata), .bank_rdata(16'h5A5A), .bank_ack(f_bank_ack),
        .busy(f_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on one port; ack_at is the WAIT cycle index of the ack
    // (-1 = never ack).
    task automatic run_txn(input int port, input logic rnw, input logic [7:0] a,
                           input logic [15:0] wd, input int ack_at, input logic [15:0] bd);
        int   n;
        int   exp_n;
        logic got;
        logic timed_out;
        if (port == 0) begin req0 = 1'b1; rnw0 = rnw; addr0 = a; wdata0 = wd; end
        else           begin req1 = 1'b1; rnw1 = rnw; addr1 = a; wdata1 = wd; end
        tick();
        check("bank_req", 32'(bank_req), 32'd1);
        check("bank_rnw", 32'(bank_rnw), 32'(rnw));
        check("bank_addr", 32'(bank_addr), 32'(a));
        if (!rnw) check("bank_wdata", 32'(bank_wdata), 32'(wd));
        if (port == 0) begin rnw0 = ~rnw; addr0 = ~a; wdata0 = ~wd; end
        else           begin rnw1 = ~rnw; addr1 = ~a; wdata1 = ~wd; end
        tick();
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            bank_ack   = (n == ack_at);
            bank_rdata = bd;
            tick();
            n++;
            got = done0 | done1;
        end
        bank_ack = 1'b0;
        timed_out = !(ack_at >= 0 && ack_at < TIMEOUT);
        exp_n = timed_out ? TIMEOUT : ack_at + 1;
        if (timed_out) begin
            if (port == 0) exp_rd0 = ERR_RDATA; else exp_rd1 = ERR_RDATA;
        end else if (rnw) begin
            if (port == 0) exp_rd0 = bd; else exp_rd1 = bd;
        end
        check("latency", 32'(n), 32'(exp_n));
        check("bank_addr_hold", 32'(bank_addr), 32'(a));
        check("done0", 32'(done0), 32'(port == 0));
        check("done1", 32'(done1), 32'(port == 1));
        check("err0", 32'(err0), 32'(port == 0 && timed_out));
        check("err1", 32'(err1), 32'(port == 1 && timed_out));
        check("rdata0", 32'(rdata0), 32'(exp_rd0));
        check("rdata1", 32'(rdata1), 32'(exp_rd1));
        $display("txn port=%0d rnw=%0b addr=%h ack_at=%0d cycles=%0d err0=%0b err1=%0b rdata0=%h rdata1=%h",
                 port, rnw, a, ack_at, n, err0, err1, rdata0, rdata1);
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        tick();
        check("done_pulse", 32'(done0 | done1), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        req0 = 1'b0; rnw0 = 1'b0; addr0 = 8'h0; wdata0 = 16'h0;
        req1 = 1'b0; rnw1 = 1'b0; addr1 = 8'h0; wdata1 = 16'h0;
        bank_ack = 1'b0; bank_rdata = 16'h0;
        f_req0 = 1'b0; f_req1 = 1'b0; f_bank_ack = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bank_req", 32'(bank_req), 32'd0);
        check("rst_done", 32'({done0, done1, err0, err1}), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        reset = 1'b0;
        tick();

        run_txn(0, 1'b1, ADDR_DEVID, 16'h0000, 0, 16'h002A);
        run_txn(1, 1'b0, 8'h20, 16'hBEEF, 0, 16'h1111);
        run_txn(1, 1'b1, ADDR_STATUS, 16'h0000, 3, 16'hC0DE);

        // Both ports held: grants must alternate 0,1,0,1.
        req0 = 1'b1; rnw0 = 1'b1; addr0 = 8'h30;
        req1 = 1'b1; rnw1 = 1'b1; addr1 = 8'h31;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!bank_req && n < 10) begin tick(); n++; end
            check("rr_grant", 32'(bank_addr), (t % 2 == 0) ? 32'h30 : 32'h31);
            tick();
            bank_ack = 1'b1; bank_rdata = 16'(16'h0100 + t);
            tick();
            bank_ack = 1'b0;
            check("rr_done0", 32'(done0), 32'(t % 2 == 0));
            check("rr_done1", 32'(done1), 32'(t % 2 == 1));
            $display("txn rr t=%0d bank_addr=%h done0=%0b done1=%0b", t, bank_addr, done0, done1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        exp_rd0 = 16'h0102;
        exp_rd1 = 16'h0103;
        check("rr_rdata0", 32'(rdata0), 32'(exp_rd0));
        check("rr_rdata1", 32'(rdata1), 32'(exp_rd1));

        // Fixed-priority instance: port 0 served every time while both held.
        f_req0 = 1'b1; f_req1 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            while (!f_bank_req && n < 10) begin tick(); n++; end
            check("fp_grant", 32'(f_bank_addr), 32'h40);
            tick();
            f_bank_ack = 1'b1;
            tick();
            f_bank_ack = 1'b0;
            check("fp_done0", 32'(f_done0), 32'd1);
            check("fp_done1", 32'(f_done1), 32'd0);
            $display("txn fp t=%0d bank_addr=%h done0=%0b done1=%0b", t, f_bank_addr, f_done0, f_done1);
        end
        f_req0 = 1'b0; f_req1 = 1'b0;
        tick(); tick();

        // Timeout, recovery, then ack on the final timeout cycle.
        run_txn(0, 1'b1, 8'h22, 16'h0000, -1, 16'h0000);
        run_txn(0, 1'b1, 8'h23, 16'h0000, 0, 16'h1234);
        run_txn(0, 1'b1, 8'h24, 16'h0000, TIMEOUT - 1, 16'hABCD);
        run_txn(1, 1'b0, 8'h25, 16'h7777, -1, 16'h0000);

        // Reset while waiting on the bank.
        req0 = 1'b1; rnw0 = 1'b1; addr0 = 8'h50;
        tick(); tick(); tick(); tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1; req0 = 1'b0;
        tick();
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_done_err", 32'({done0, done1, err0, err1}), 32'd0);
        check("wrst_rdata0", 32'(rdata0), 32'd0);
        check("wrst_rdata1", 32'(rdata1), 32'd0);
        reset = 1'b0;
        exp_rd0 = 16'h0; exp_rd1 = 16'h0;
        bank_ack = 1'b1; bank_rdata = 16'hDEAD;
        tick();
        bank_ack = 1'b0;
        tick();
        check("late_ack_done", 32'({done0, done1}), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);
        $display("txn reset-in-wait busy=%0b done0=%0b rdata0=%h", busy, done0, rdata0);
        req0 = 1'b1; rnw0 = 1'b1; addr0 = 8'h60;
        req1 = 1'b1; rnw1 = 1'b1; addr1 = 8'h61;
        tick();
        check("post_rst_tie", 32'(bank_addr), 32'h60);
        tick();
        bank_ack = 1'b1; bank_rdata = 16'h4242;
        tick();
        bank_ack = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        check("post_rst_done0", 32'(done0), 32'd1);
        check("post_rst_rdata0", 32'(rdata0), 32'h4242);
        $display("txn post-reset tie bank_addr=%h done0=%0b rdata0=%h", bank_addr, done0, rdata0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
